// File: rtl/pmod_ad1_reader.sv
// PmodAD1 dual 12-bit ADC reader: a START rising edge runs one 16-SCLK frame and yields DATA0/DATA1 with a VALID pulse.
// Optional macro PMOD_AD1_OVERRUN_EN adds OVERRUN_CNT, a saturating count of START edges ignored while BUSY.
module pmod_ad1_reader #(
  parameter int CLK_DIV   = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SDATA0,
  input  logic        SDATA1,
  output logic        CS_N,
  output logic        SCLK,
  output logic [11:0] DATA0,
  output logic [11:0] DATA1,
  output logic        VALID,
  output logic        BUSY
`ifdef PMOD_AD1_OVERRUN_EN
  ,
  output logic [7:0]  OVERRUN_CNT
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_QUIET} state_t;

  state_t          r_state;
  logic            r_start_q;
  logic            r_cs_n;
  logic            r_sclk;
  logic            r_valid;
  logic            r_busy;
  logic [DW-1:0]   r_div_cnt;
  logic [4:0]      r_bit_cnt;
  logic [QW-1:0]   r_q_cnt;
  logic [15:0]     r_sh0;
  logic [15:0]     r_sh1;
  logic [11:0]     r_data0;
  logic [11:0]     r_data1;

  logic w_edge;
  assign w_edge = START & ~r_start_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // start_q resets high so a START already high at release is not an edge
      r_start_q <= 1'b1;
      r_state   <= S_IDLE;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_q_cnt   <= '0;
      r_sh0     <= '0;
      r_sh1     <= '0;
      r_data0   <= '0;
      r_data1   <= '0;
    end else begin
      r_start_q <= START;
      r_valid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state   <= S_CONVERT;
            r_busy    <= 1'b1;
            r_cs_n    <= 1'b0;
            r_sclk    <= 1'b1;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_CONVERT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
            if (!r_sclk) begin
              r_sh0     <= {r_sh0[14:0], SDATA0};
              r_sh1     <= {r_sh1[14:0], SDATA1};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              // 16th rising edge closes the frame with SCLK left high
              if (r_bit_cnt == 5'd15) begin
                r_state <= S_QUIET;
                r_cs_n  <= 1'b1;
                r_q_cnt <= '0;
                r_data0 <= {r_sh0[10:0], SDATA0};
                r_data1 <= {r_sh1[10:0], SDATA1};
                r_valid <= 1'b1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end
        S_QUIET: begin
          if (r_q_cnt == Q_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_q_cnt <= r_q_cnt + QW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PMOD_AD1_OVERRUN_EN
  logic [7:0] r_overrun_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_overrun_cnt <= '0;
    end else if (w_edge && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end
  assign OVERRUN_CNT = r_overrun_cnt;
`endif

  assign CS_N  = r_cs_n;
  assign SCLK  = r_sclk;
  assign DATA0 = r_data0;
  assign DATA1 = r_data1;
  assign VALID = r_valid;
  assign BUSY  = r_busy;

endmodule

// File: tb/tb_pmod_ad1_reader.sv
// Directed and randomized bench for pmod_ad1_reader with a serial ADC model and immediate-assertion checks.
// Define PMOD_AD1_OVERRUN_EN to also exercise the overrun counter.
module tb_pmod_ad1_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sdata0 = 1'b0;
  logic        sdata1 = 1'b0;
  logic        cs_n;
  logic        sclk;
  logic [11:0] data0;
  logic [11:0] data1;
  logic        valid;
  logic        busy;
`ifdef PMOD_AD1_OVERRUN_EN
  logic [7:0]  overrun_cnt;
`endif

  pmod_ad1_reader #(.CLK_DIV(4), .QUIET_CYC(8)) dut (
    .CLK(clk),
    .RST(rst),
    .START(start),
    .SDATA0(sdata0),
    .SDATA1(sdata1),
    .CS_N(cs_n),
    .SCLK(sclk),
    .DATA0(data0),
    .DATA1(data1),
    .VALID(valid),
    .BUSY(busy)
`ifdef PMOD_AD1_OVERRUN_EN
    ,
    .OVERRUN_CNT(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ADC model: next bit (MSB first) presented on each SCLK fall while selected
  logic [15:0] adc_w0 = 16'h0;
  logic [15:0] adc_w1 = 16'h0;
  int          adc_idx = 0;
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) begin
      adc_idx = 0;
    end else if (adc_idx < 16) begin
      sdata0  = adc_w0[15 - adc_idx];
      sdata1  = adc_w1[15 - adc_idx];
      adc_idx = adc_idx + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Frame observations
  int          m_lat, m_cs_low, m_rises, m_valids;
  logic        m_sclk_at_cs_rise, m_done;
  logic [11:0] m_d0, m_d1;

  // Raise START, watch one frame; extra_at>0 injects a second edge, rst_at>0 resets at that SCLK rise
  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1,
                           input int extra_at, input int rst_at);
    int   n;
    logic seen_low, prev_sclk, rst_done;
    adc_w0 = w0;
    adc_w1 = w1;
    m_lat = -1; m_cs_low = 0; m_rises = 0; m_valids = 0;
    m_sclk_at_cs_rise = 1'b0; m_done = 1'b0; m_d0 = 'x; m_d1 = 'x;
    seen_low = 1'b0; prev_sclk = sclk; rst_done = 1'b0; n = 0;
    start = 1'b1;
    while (n < 600 && !(m_done && !busy)) begin
      cyc();
      n++;
      if (n == 10) start = 1'b0;
      if (extra_at > 0 && n == extra_at) start = 1'b1;
      if (extra_at > 0 && n == extra_at + 3) start = 1'b0;
      if (rst_done) begin
        rst = 1'b0;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_data0", 32'(data0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_done = 1'b0;
      end
      if (!seen_low && !cs_n) begin
        seen_low = 1'b1;
        m_lat = n;
      end
      if (seen_low && !m_done) begin
        if (!cs_n) m_cs_low++;
        if (sclk && !prev_sclk) m_rises++;
        if (cs_n) begin
          m_done = 1'b1;
          m_sclk_at_cs_rise = sclk;
        end
      end
      if (valid) begin
        m_valids++;
        m_d0 = data0;
        m_d1 = data1;
      end
      if (rst_at > 0 && m_rises == rst_at && !m_done && rst == 1'b0 && !rst_done) begin
        rst = 1'b1;
        rst_done = 1'b1;
      end
      prev_sclk = sclk;
    end
    chk("frame_timeout", 32'(m_done), 32'd1);
    start = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    int nvalid;
    int nlow;
    logic [15:0] rw0, rw1;

    rst = 1'b1;
    start = 1'b0;
    repeat (3) cyc();
    chk("reset_cs_n", 32'(cs_n), 32'd1);
    chk("reset_sclk", 32'(sclk), 32'd1);
    chk("reset_data0", 32'(data0), 32'd0);
    chk("reset_data1", 32'(data1), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
`ifdef PMOD_AD1_OVERRUN_EN
    chk("reset_overrun", 32'(overrun_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (3) cyc();

    // Frame timing and basic data
    run_frame(16'h0ABC, 16'h0123, 0, 0);
    chk("t1_latency", 32'(m_lat), 32'd1);
    chk("t1_cs_low_cycles", 32'(m_cs_low), 32'd128);
    chk("t1_sclk_rises", 32'(m_rises), 32'd16);
    chk("t1_sclk_at_cs_rise", 32'(m_sclk_at_cs_rise), 32'd1);
    chk("t2_valid_count", 32'(m_valids), 32'd1);
    chk("t2_data0", 32'(m_d0), 32'hABC);
    chk("t2_data1", 32'(m_d1), 32'h123);
    chk("t2_data0_hold", 32'(data0), 32'hABC);

    // Leading bits discarded
    run_frame(16'hF5A5, 16'hFFFF, 0, 0);
    chk("t3_data0", 32'(m_d0), 32'h5A5);
    chk("t3_data1", 32'(m_d1), 32'hFFF);

    // Second edge during CONVERT ignored
    run_frame(16'h1357, 16'h2468, 50, 0);
    chk("t4_valid_count", 32'(m_valids), 32'd1);
    chk("t4_cs_low_cycles", 32'(m_cs_low), 32'd128);
    chk("t4_data0", 32'(m_d0), 32'h357);
    chk("t4_data1", 32'(m_d1), 32'h468);
`ifdef PMOD_AD1_OVERRUN_EN
    chk("t4_overrun_one", 32'(overrun_cnt), 32'd1);
    // Edges every 2 cycles: nearly all land while busy, so the count saturates
    for (int i = 0; i < 300; i++) begin
      start = 1'b1; cyc();
      start = 1'b0; cyc();
    end
    repeat (200) cyc();
    chk("t4_overrun_sat", 32'(overrun_cnt), 32'd255);
`endif

    // Randomized frames against the reference: data = low 12 bits of the word
    for (int i = 0; i < 6; i++) begin
      rw0 = 16'($urandom);
      rw1 = 16'($urandom);
      run_frame(rw0, rw1, 0, 0);
      chk("rand_valid_count", 32'(m_valids), 32'd1);
      chk("rand_data0", 32'(m_d0), 32'(rw0[11:0]));
      chk("rand_data1", 32'(m_d1), 32'(rw1[11:0]));
    end

    // Reset mid-frame at SCLK rise 8
    run_frame(16'h0FED, 16'h0CBA, 0, 8);
    chk("t5_no_valid", 32'(m_valids), 32'd0);
    chk("t5_partial_rises", 32'(m_rises), 32'd8);
    nvalid = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (valid) nvalid++;
    end
    chk("t5_no_late_valid", 32'(nvalid), 32'd0);
    run_frame(16'h0246, 16'h0ACE, 0, 0);
    chk("t5_after_rst_data0", 32'(m_d0), 32'h246);
    chk("t5_after_rst_data1", 32'(m_d1), 32'hACE);

    // START held high across reset release does not start a frame
    start = 1'b1;
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    nlow = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!cs_n || busy) nlow++;
    end
    chk("t6_no_frame", 32'(nlow), 32'd0);
`ifdef PMOD_AD1_OVERRUN_EN
    chk("t6_overrun_cleared", 32'(overrun_cnt), 32'd0);
`endif
    start = 1'b0;
    repeat (2) cyc();
    run_frame(16'h0777, 16'h0888, 0, 0);
    chk("t6_frame_lat", 32'(m_lat), 32'd1);
    chk("t6_data0", 32'(m_d0), 32'h777);
    chk("t6_data1", 32'(m_d1), 32'h888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
